pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register. Successor to the fixed 32-bit load/hold register.
- Generalises data width and reset value.
- Replaces the single enable with a valid/ready handshake on both sides.
- Adds a 2-entry skid buffer so in_ready is a registered signal, plus a synchronous flush for branch/exception squash.
- Placed between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- WIDTH, 32: payload width in bits, >=1.
- RESET_VALUE, 0: value driven on out_data while empty, after reset and after flush; WIDTH bits.
- CNT_WIDTH, 32: width of the performance counters; only used with PIPE_STAGE_PERF_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; driven straight from a register.
- in_data  input  WIDTH  upstream payload, signed.
- out_valid  output  1  main entry holds valid payload.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  main entry payload, signed.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cnt  output  CNT_WIDTH  backpressure cycle count; present only with PIPE_STAGE_PERF_EN.
- drop_cnt  output  CNT_WIDTH  entries discarded by flush; present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Storage: main entry (main_v, main_d) drives the outputs; skid entry (skid_v, skid_d).
- State encoding: EMPTY (0 entries), ONE (main_v only), FULL (main_v and skid_v). skid_v without main_v is illegal.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both may happen in the same cycle.
- Outputs: in_ready = !skid_v (registered); out_valid = main_v; out_data = main_d; occupancy = main_v + skid_v.
- Reset values: main_v = skid_v = 0; main_d = skid_d = RESET_VALUE; in_ready = 1; out_valid = 0; out_data = RESET_VALUE; occupancy = 0; counters = 0.
- Latency: 1 cycle. Data accepted at edge N appears on out_data after edge N when the stage was empty or the main entry was draining.
- Throughput: 1 item per cycle with out_ready held high.
- EMPTY:
  - in_fire: load main, go to ONE.
  - No in_fire: stay in EMPTY.
- ONE:
  - in_fire and out_fire: main takes in_data, stay in ONE.
  - in_fire only: skid takes in_data, go to FULL.
  - out_fire only: main_d returns to RESET_VALUE, go to EMPTY.
  - Neither: hold.
- FULL (in_ready = 0, so no in_fire is possible):
  - out_fire: main takes skid_d, skid clears, go to ONE.
  - No out_fire: hold.
- Data stability: main_d, and therefore out_data, never changes while out_valid=1 and out_ready=0.
- Flush:
  - Priority: rst > flush > handshake.
  - At the edge: main_v = skid_v = 0; both data registers = RESET_VALUE; state = EMPTY; in_ready = 1 next cycle.
  - Any in_fire or out_fire in the flush cycle is ignored.
  - Upstream must treat an in_fire during flush as consumed and discarded.
  - Downstream must not commit an out_fire during flush.
- Reset mid-operation: contents are discarded identically to flush, and counters also clear.
- Arithmetic: occupancy is a 2-bit sum.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0, and not in a flush cycle.
  - drop_cnt adds occupancy on each flush cycle.
  - Both counters saturate at all-ones rather than wrapping.
  - Both clear on rst only.
- Not defined: stall_cnt/drop_cnt ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'h1234 -> out_valid=0, out_data=0, in_ready=1, occupancy=0; after release, first in_fire of 32'h1234 appears 1 cycle later.
- Streaming: out_ready=1; push 5,6,7,8 on consecutive cycles -> out_data shows 5,6,7,8 on consecutive cycles, in_ready stays 1, occupancy stays 1.
- Backpressure: out_ready=0; push 0xA then 0xB -> occupancy=2, in_ready=0, out_data holds 0xA; raise out_ready -> 0xA, then 0xB, no loss or duplication, in_ready=1 one cycle after the first out_fire.
- Flush in FULL: entries 0xA,0xB held; flush=1 with in_valid=1, in_data=0xC, out_ready=1 -> next cycle out_valid=0, occupancy=0, out_data=RESET_VALUE, 0xC absent; with PIPE_STAGE_PERF_EN, drop_cnt=2.
- Signed payload, WIDTH=8, RESET_VALUE=8'h7F: push -3 (8'hFD) -> out_data=8'hFD; after drain -> out_data=8'h7F.
- Perf counters (PIPE_STAGE_PERF_EN, CNT_WIDTH=3): hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=7 (saturates); rst -> 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready on both sides, 2-entry skid buffer, synchronous flush.
// Optional performance counters (stall_cnt, drop_cnt) are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       CNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [1:0]              occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]    stall_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and data stable until that transfer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_stage_reg: WIDTH must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("pipe_stage_reg: CNT_WIDTH must be >= 1");
    end

    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   main_d_q, main_d_n;
    logic signed [WIDTH-1:0]   skid_d_q, skid_d_n;
    logic                      in_ready_q;
    logic                      main_v, skid_v;
    logic                      in_fire, out_fire;

    assign main_v    = (state_q != EMPTY);
    assign skid_v    = (state_q == FULL);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = main_v & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = main_v;
    assign out_data  = main_d_q;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    always_comb begin
        state_d  = state_q;
        main_d_n = main_d_q;
        skid_d_n = skid_d_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d_n = in_data;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d_n = in_data;
                end else if (in_fire) begin
                    skid_d_n = in_data;
                    state_d  = FULL;
                end else if (out_fire) begin
                    main_d_n = RESET_VALUE;
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move
                if (out_fire) begin
                    main_d_n = skid_d_q;
                    skid_d_n = RESET_VALUE;
                    state_d  = ONE;
                end
            end
            default: begin
                state_d  = EMPTY;
                main_d_n = RESET_VALUE;
                skid_d_n = RESET_VALUE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= EMPTY;
            main_d_q   <= RESET_VALUE;
            skid_d_q   <= RESET_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_d_q   <= main_d_n;
            skid_d_q   <= skid_d_n;
            in_ready_q <= (state_d != FULL);
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_WIDTH:0]   drop_sum;
    logic [CNT_WIDTH-1:0] drop_next;

    // Saturating add of the entries squashed this cycle
    assign drop_sum  = {1'b0, drop_cnt} + (CNT_WIDTH+1)'(occupancy);
    assign drop_next = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            drop_cnt  <= drop_next;
        end else if (main_v && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed plan plus random traffic against a queue-based model.
// Two instances share stimulus: 32-bit/RESET_VALUE 0 and 8-bit/RESET_VALUE 8'h7F.
module tb_pipe_stage_reg;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [7:0]  in_data_b;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a;
    logic [7:0]  out_data_b;
    logic [1:0]  occ_a, occ_b;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_a, drop_a, stall_b, drop_b;
`endif

    int checks   = 0;
    int failures = 0;

    // Scoreboard: payloads currently held by the stage, oldest first
    logic [31:0] exp_q[$];
    int          stall_m = 0;
    int          drop_m  = 0;

    assign in_data_b = in_data[7:0];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(32'h0), .CNT_WIDTH(CNT_W)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occupancy(occ_a)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_a), .drop_cnt(drop_a)
`endif
    );

    pipe_stage_reg #(.WIDTH(8), .RESET_VALUE(8'h7F), .CNT_WIDTH(CNT_W)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occ_b)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_b), .drop_cnt(drop_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic f, input logic iv,
                                input logic [31:0] d, input logic ordy);
        int n;
        n = exp_q.size();
        if (r) begin
            exp_q.delete();
            stall_m = 0;
            drop_m  = 0;
        end else if (f) begin
            drop_m = (drop_m + n > CNT_MAX) ? CNT_MAX : drop_m + n;
            exp_q.delete();
        end else begin
            if (n > 0 && !ordy && stall_m < CNT_MAX) stall_m++;
            if (n > 0 && ordy) void'(exp_q.pop_front());
            if (iv && n < 2) exp_q.push_back(d);
        end
    endtask

    task automatic check_outputs();
        int          n;
        logic [31:0] head;
        n    = exp_q.size();
        head = (n > 0) ? exp_q[0] : 32'h0;
        check_eq("a_in_ready",  {31'b0, in_ready_a},  {31'b0, n < 2});
        check_eq("a_out_valid", {31'b0, out_valid_a}, {31'b0, n > 0});
        check_eq("a_out_data",  out_data_a,           head);
        check_eq("a_occupancy", {30'b0, occ_a},       n);
        check_eq("b_in_ready",  {31'b0, in_ready_b},  {31'b0, n < 2});
        check_eq("b_out_data",  {24'b0, out_data_b},  (n > 0) ? {24'b0, head[7:0]} : 32'h7F);
        check_eq("b_occupancy", {30'b0, occ_b},       n);
`ifdef PIPE_STAGE_PERF_EN
        check_eq("a_stall_cnt", {29'b0, stall_a}, stall_m);
        check_eq("a_drop_cnt",  {29'b0, drop_a},  drop_m);
        check_eq("b_stall_cnt", {29'b0, stall_b}, stall_m);
        check_eq("b_drop_cnt",  {29'b0, drop_b},  drop_m);
`endif
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        model_update(r, f, iv, d, ordy);
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset with a live upstream: nothing may be captured
        step(1'b1, 1'b0, 1'b1, 32'h1234, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h1234, 1'b0);
        check_eq("rst_out_valid", {31'b0, out_valid_a}, 32'h0);
        check_eq("rst_out_data",  out_data_a, 32'h0);
        check_eq("rst_in_ready",  {31'b0, in_ready_a}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 32'h1234, 1'b1);
        check_eq("first_out", out_data_a, 32'h1234);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Streaming at full rate
        for (int i = 5; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b1, i, 1'b1);
            check_eq("stream_data", out_data_a, i);
            check_eq("stream_occ",  {30'b0, occ_a}, 32'h1);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure fills the skid, then drain in order
        step(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hEE, 1'b0);
        check_eq("bp_occ",      {30'b0, occ_a}, 32'h2);
        check_eq("bp_in_ready", {31'b0, in_ready_a}, 32'h0);
        check_eq("bp_hold",     out_data_a, 32'hA);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("bp_second",   out_data_a, 32'hB);
        check_eq("bp_ready_back", {31'b0, in_ready_a}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush while FULL, with an offered input and a ready downstream
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'hC, 1'b1);
        check_eq("flush_valid", {31'b0, out_valid_a}, 32'h0);
        check_eq("flush_occ",   {30'b0, occ_a}, 32'h0);
        check_eq("flush_b_data", {24'b0, out_data_b}, 32'h7F);
`ifdef PIPE_STAGE_PERF_EN
        check_eq("flush_drop", {29'b0, drop_a}, 32'h2);
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Signed payload on the 8-bit instance
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
        check_eq("signed_b", {24'b0, out_data_b}, 32'hFD);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("signed_drain", {24'b0, out_data_b}, 32'h7F);

        // Long stall saturates the counter, reset clears it
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check_eq("stall_sat", {29'b0, stall_a}, 32'h7);
`endif
        check_eq("stall_hold", out_data_a, 32'h55);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
